// File: rtl/loader_pkg.sv
// Shared state encoding and default session geometry for the host loader.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    KICK,
    RUN,
    DRAIN,
    FIN
  } state_t;

  localparam logic [7:0]  LD_BASE_DEF = 8'd0;
  localparam logic [8:0]  LD_LEN_DEF  = 9'd64;
  localparam logic [7:0]  RS_BASE_DEF = 8'd64;
  localparam logic [8:0]  RS_LEN_DEF  = 9'd64;
  localparam logic [19:0] TMO_DEF     = 20'd100000;

endpackage

// File: rtl/host_loader.sv
// Host session sequencer: loads bytes into data memory, runs the core, streams results back.
// Byte handshakes are combinational (same-cycle); in_valid/out_ready stalls hold all state.
module host_loader
  import loader_pkg::*;
#(
  parameter logic [7:0]  LD_BASE = LD_BASE_DEF,
  parameter logic [8:0]  LD_LEN  = LD_LEN_DEF,
  parameter logic [7:0]  RS_BASE = RS_BASE_DEF,
  parameter logic [8:0]  RS_LEN  = RS_LEN_DEF,
  parameter logic [19:0] TMO     = TMO_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       mem_wr_en,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wr_dat,
  input  logic [7:0] mem_rd_dat,
  output logic       core_reset,
  input  logic       core_done,
  output logic       busy,
  output logic       timeout
);

  state_t      state, state_nxt;
  logic [8:0]  idx, idx_nxt;
  logic [19:0] cnt, cnt_nxt;
  logic        timeout_q, timeout_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      idx       <= '0;
      cnt       <= '0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      cnt       <= cnt_nxt;
      timeout_q <= timeout_nxt;
    end
  end

  assign timeout = timeout_q;

  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    cnt_nxt     = cnt;
    timeout_nxt = timeout_q;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_data    = 8'd0;
    mem_wr_en   = 1'b0;
    mem_addr    = 8'd0;
    mem_wr_dat  = 8'd0;
    core_reset  = 1'b1;
    busy        = 1'b1;

    unique case (state)
      IDLE: begin
        busy    = 1'b0;
        idx_nxt = '0;
        if (start) begin
          timeout_nxt = 1'b0;
          state_nxt   = (LD_LEN == 9'd0) ? KICK : LOAD;
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        mem_addr = LD_BASE + idx[7:0];
        if (in_valid) begin
          mem_wr_en  = 1'b1;
          mem_wr_dat = in_data;
          idx_nxt    = idx + 9'd1;
          if (idx == LD_LEN - 9'd1) state_nxt = KICK;
        end
      end
      KICK: begin
        cnt_nxt   = '0;
        idx_nxt   = '0;
        state_nxt = RUN;
      end
      RUN: begin
        core_reset = 1'b0;
        idx_nxt    = '0;
        // A done arriving on the last allowed cycle still counts as success.
        if (core_done) begin
          state_nxt = (RS_LEN == 9'd0) ? FIN : DRAIN;
        end else if (cnt == TMO - 20'd1) begin
          state_nxt   = FIN;
          timeout_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 20'd1;
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        mem_addr  = RS_BASE + idx[7:0];
        out_data  = mem_rd_dat;
        if (out_ready) begin
          idx_nxt = idx + 9'd1;
          if (idx == RS_LEN - 9'd1) state_nxt = FIN;
        end
      end
      FIN: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: doc/host_loader.md
HOST_LOADER -- requirements
Module: host_loader

Interface
REQ-001 Parameter LD_BASE, default 8'd0, first data-memory address written during load.
REQ-002 Parameter LD_LEN, default 9'd64, bytes loaded (0..256).
REQ-003 Parameter RS_BASE, default 8'd64, first data-memory address read back.
REQ-004 Parameter RS_LEN, default 9'd64, bytes streamed out (0..256).
REQ-005 Parameter TMO, default 20'd100000, maximum core run cycles.
REQ-006 Ports (name, direction, width, meaning):
- clk  in  1  single clock.
- reset  in  1  asynchronous active-low reset.
- start  in  1  host request to begin a session.
- in_valid  in  1  load byte valid.
- in_data  in  8  load byte.
- in_ready  out  1  load byte accepted when in_valid & in_ready.
- out_valid  out  1  result byte valid.
- out_data  out  8  result byte.
- out_ready  in  1  result byte taken when out_valid & out_ready.
- mem_wr_en  out  1  data-memory write strobe.
- mem_addr  out  8  data-memory address.
- mem_wr_dat  out  8  data-memory write data.
- mem_rd_dat  in  8  data-memory read data, combinational from mem_addr.
- core_reset  out  1  active-high hold for the core.
- core_done  in  1  core finished.
- busy  out  1  session in progress.
- timeout  out  1  last session ended by TMO.

Function
REQ-007 FSM states: IDLE, LOAD, KICK, RUN, DRAIN, FIN.
REQ-008 IDLE: when start=1 the block SHALL go to LOAD; if LD_LEN=0 it goes directly to KICK.
REQ-009 IDLE: start=1 SHALL clear timeout. start SHALL be ignored in all other states.
REQ-010 LOAD: in_ready=1. Each handshake SHALL assert mem_wr_en for that same cycle, with mem_addr=LD_BASE+idx (mod 256), mem_wr_dat=in_data, and idx incremented.
REQ-011 LOAD: the handshake that accepts byte LD_LEN-1 SHALL move the FSM to KICK. in_valid=0 stalls the load indefinitely.
REQ-012 in_ready SHALL be 0 outside LOAD; in_valid outside LOAD SHALL be ignored.
REQ-013 core_reset SHALL be 1 in every state except RUN.
REQ-014 KICK lasts one cycle and clears the cycle counter.
REQ-015 RUN: core_done is sampled only in RUN, starting with the first RUN cycle.
REQ-016 RUN: core_done=1 SHALL move the FSM to DRAIN, or to FIN if RS_LEN=0.
REQ-017 RUN: if the counter reaches TMO-1 without core_done, the FSM SHALL go to FIN with timeout=1 and no result output. If core_done and timeout occur in the same cycle, core_done wins.
REQ-018 DRAIN: mem_addr=RS_BASE+idx (mod 256), out_data=mem_rd_dat, out_valid=1.
REQ-019 DRAIN: out_valid, out_data and mem_addr SHALL stay stable while out_ready=0.
REQ-020 DRAIN: each handshake SHALL increment idx; the handshake on byte RS_LEN-1 SHALL move the FSM to FIN.
REQ-021 FIN lasts one cycle, then returns to IDLE. busy=1 in every state except IDLE.
REQ-022 mem_wr_en SHALL be 1 only on a LOAD handshake cycle. mem_addr SHALL be 0 and out_valid SHALL be 0 in IDLE, KICK, RUN and FIN.
REQ-023 idx is 9 bits and resets to 0 on entry to LOAD and to DRAIN. Address arithmetic uses idx[7:0] and wraps modulo 256.

Reset
REQ-024 reset=0 SHALL, asynchronously: force IDLE; zero idx, counter and timeout; drive core_reset=1 and every other output to 0. This applies mid-session.
REQ-025 After reset rises, the block SHALL accept start on the first clk edge.

Structure
REQ-026 Package loader_pkg SHALL hold the state enum and the default values of LD_BASE, LD_LEN, RS_BASE, RS_LEN and TMO.
REQ-027 No sub-module is needed: one FSM, one index counter and one run counter in a single module.
REQ-028 mem_* ports SHALL connect to the data-memory port of the processor (dat_mem) through a top-level mux that selects host_loader whenever core_reset=1.

Verification
REQ-029 Full session: LD_LEN=4, bytes 11,22,33,44 -> writes at 0..3; core_done after 10 RUN cycles; RS_LEN=2 with memory[64..65]=AA,BB -> out AA then BB; busy falls after FIN.
REQ-030 Backpressure: in_valid toggled every cycle and out_ready low 3 cycles per byte -> no byte lost or duplicated; out_data stable while stalled.
REQ-031 Timeout: TMO=16, core_done never asserted -> FIN after 16 RUN cycles, timeout=1, out_valid never 1; the next start clears timeout.
REQ-032 Wrap and zero-length: LD_BASE=254, LD_LEN=4 -> writes at 254,255,0,1. RS_LEN=0 -> RUN goes straight to FIN.
REQ-033 Reset mid-DRAIN: reset low for 1 cycle -> outputs zero immediately, core_reset=1, IDLE; a new start gives a correct full session.
REQ-034 core_done held high in IDLE/LOAD -> ignored; start pulsed during RUN -> ignored.
